// File: rtl/serial_twos_packer_if.sv
// Serial-in / parallel-out bus of the two's-complement packer.
// The packer connects through master; the bit source and word consumer use slave.
interface serial_twos_packer_if #(
  parameter int WIDTH = 8
);
  logic             bit_in;
  logic             bit_valid;
  logic             frame_start;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic             carry_out;
  logic             overrun;

  modport master (
    input  bit_in, bit_valid, frame_start, word_ready,
    output word_out, word_valid, carry_out, overrun
  );

  modport slave (
    output bit_in, bit_valid, frame_start, word_ready,
    input  word_out, word_valid, carry_out, overrun
  );
endinterface

// File: rtl/serial_twos_packer.sv
// Adds 1 bit-serially to an LSB-first one's-complement stream and packs the
// resulting two's-complement word into a one-entry valid/ready buffer.
module serial_twos_packer #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_twos_packer_if.master  bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             carry_r, carry_s;
  logic [WIDTH-1:0] shreg_r, shreg_s;
  logic [WIDTH-1:0] word_r, word_s;
  logic             carry_out_r, carry_out_s;
  logic             word_valid_r, word_valid_s;
  logic             overrun_r, overrun_s;

  logic             start_s;
  logic             sum_s;
  logic             carry_nxt_s;
  logic             complete_s;
  logic [WIDTH-1:0] word_nxt_s;

  assign start_s = bus.bit_valid & bus.frame_start;

  // Frame FSM: bit absorption, serial +1 and completion detection.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    carry_s     = carry_r;
    shreg_s     = shreg_r;
    sum_s       = 1'b0;
    carry_nxt_s = 1'b0;
    complete_s  = 1'b0;
    word_nxt_s  = '0;
    if (start_s) begin
      // A start always wins: it opens a new frame and drops any partial one.
      sum_s   = ~bus.bit_in;
      shreg_s = {sum_s, shreg_r[WIDTH-1:1]};
      carry_s = bus.bit_in;
      cnt_s   = CNT_ONE;
      state_s = SHIFT;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        SHIFT: begin
          if (bus.bit_valid) begin
            sum_s       = bus.bit_in ^ carry_r;
            carry_nxt_s = bus.bit_in & carry_r;
            shreg_s     = {sum_s, shreg_r[WIDTH-1:1]};
            if (cnt_r == CNT_LAST) begin
              complete_s = 1'b1;
              word_nxt_s = {sum_s, shreg_r[WIDTH-1:1]};
              carry_s    = 1'b1;
              cnt_s      = '0;
              state_s    = IDLE;
            end else begin
              carry_s = carry_nxt_s;
              cnt_s   = cnt_r + CNT_ONE;
              state_s = SHIFT;
            end
          end else begin
            state_s = SHIFT;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = '0;
          carry_s = 1'b1;
        end
      endcase
    end
  end

  // Output buffer: load, drop-with-overrun, or drain on handshake.
  always_comb begin
    word_s       = word_r;
    carry_out_s  = carry_out_r;
    word_valid_s = word_valid_r;
    overrun_s    = 1'b0;
    if (complete_s && (!word_valid_r || bus.word_ready)) begin
      word_s       = word_nxt_s;
      carry_out_s  = carry_nxt_s;
      word_valid_s = 1'b1;
    end else if (complete_s) begin
      overrun_s = 1'b1;
    end else if (word_valid_r && bus.word_ready) begin
      word_valid_s = 1'b0;
    end else begin
      word_valid_s = word_valid_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      carry_r      <= 1'b1;
      shreg_r      <= '0;
      word_r       <= '0;
      carry_out_r  <= 1'b0;
      word_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      carry_r      <= carry_s;
      shreg_r      <= shreg_s;
      word_r       <= word_s;
      carry_out_r  <= carry_out_s;
      word_valid_r <= word_valid_s;
      overrun_r    <= overrun_s;
    end
  end

  assign bus.word_out   = word_r;
  assign bus.carry_out  = carry_out_r;
  assign bus.word_valid = word_valid_r;
  assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_serial_twos_packer.sv
// Randomized self-checking bench for serial_twos_packer against a frame-level
// arithmetic reference model.
module tb_serial_twos_packer;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  serial_twos_packer_if #(.WIDTH(W)) bus ();

  serial_twos_packer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: collected frame bits and the expected output buffer.
  int           m_nbits;
  logic [W-1:0] m_fval;
  logic [W-1:0] m_word;
  logic         m_carry;
  logic         m_valid;
  logic         m_ovr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_nbits = 0;
    m_fval  = '0;
    m_word  = '0;
    m_carry = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(bus.word_valid), 32'(m_valid));
    check_eq({tag, "_ovr"},   32'(bus.overrun),    32'(m_ovr));
    check_eq({tag, "_word"},  32'(bus.word_out),   32'(m_word));
    check_eq({tag, "_carry"}, 32'(bus.carry_out),  32'(m_carry));
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cycle(input logic bv, input logic fs, input logic b, input logic rdy);
    logic         done;
    logic [W:0]   res;
    bus.bit_valid   = bv;
    bus.frame_start = fs;
    bus.bit_in      = b;
    bus.word_ready  = rdy;
    done = 1'b0;
    res  = '0;
    if (bv && fs) begin
      m_fval    = '0;
      m_fval[0] = b;
      m_nbits   = 1;
    end else if (bv && m_nbits > 0) begin
      m_fval[m_nbits] = b;
      m_nbits++;
      if (m_nbits == W) begin
        done    = 1'b1;
        res     = {1'b0, m_fval} + (W+1)'(1);
        m_nbits = 0;
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_word  = res[W-1:0];
        m_carry = res[W];
        m_valid = 1'b1;
        m_ovr   = 1'b0;
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      m_ovr = 1'b0;
      if (m_valid && rdy) m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  task automatic send_frame(input logic [W-1:0] v, input logic rdy_body,
                            input logic rdy_last, input int gap_pct);
    for (int i = 0; i < W; i++) begin
      while (int'($urandom_range(99)) < gap_pct)
        cycle(1'b0, 1'b0, 1'($urandom_range(1)), rdy_body);
      cycle(1'b1, (i == 0), v[i], (i == W-1) ? rdy_last : rdy_body);
    end
  endtask

  task automatic async_reset();
    bus.bit_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.word_ready  = 1'b0;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    #2;
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    rst             = 1'b0;
    bus.bit_in      = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.word_ready  = 1'b0;
    #2;
    check_outputs("por");
    #5;
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Basic conversion and the all-ones / all-zeros corners.
    send_frame(8'hFA, 1'b1, 1'b1, 0);
    check_eq("basic_word", 32'(bus.word_out), 32'h0000_00FB);
    check_eq("basic_valid", 32'(bus.word_valid), 32'h0000_0001);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("basic_pulse", 32'(bus.word_valid), 32'h0000_0000);
    send_frame(8'hFF, 1'b1, 1'b1, 0);
    check_eq("ones_word", 32'(bus.word_out), 32'h0000_0000);
    check_eq("ones_carry", 32'(bus.carry_out), 32'h0000_0001);
    send_frame(8'h00, 1'b1, 1'b1, 0);
    check_eq("zero_word", 32'(bus.word_out), 32'h0000_0001);
    check_eq("zero_carry", 32'(bus.carry_out), 32'h0000_0000);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure: second frame is dropped with a single overrun pulse.
    send_frame(8'hFA, 1'b0, 1'b0, 0);
    send_frame(8'hF0, 1'b0, 1'b0, 0);
    check_eq("bp_ovr", 32'(bus.overrun), 32'h0000_0001);
    check_eq("bp_hold", 32'(bus.word_out), 32'h0000_00FB);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("bp_ovr_end", 32'(bus.overrun), 32'h0000_0000);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("bp_drain", 32'(bus.word_valid), 32'h0000_0000);

    // Completion and handshake in the same cycle.
    send_frame(8'hFA, 1'b0, 1'b0, 0);
    send_frame(8'h7F, 1'b0, 1'b1, 0);
    check_eq("sim_word", 32'(bus.word_out), 32'h0000_0080);
    check_eq("sim_valid", 32'(bus.word_valid), 32'h0000_0001);
    check_eq("sim_ovr", 32'(bus.overrun), 32'h0000_0000);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Abort a partial frame, then a gappy full frame.
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h0E, 1'b0, 1'b0, 40);
    check_eq("abort_word", 32'(bus.word_out), 32'h0000_000F);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'($urandom_range(1)), 1'b1);
    check_eq("idle_ignore", 32'(bus.word_valid), 32'h0000_0000);

    // Reset mid-frame with a word pending.
    send_frame(8'h12, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) cycle(1'b1, (i == 0), 1'b1, 1'b0);
    async_reset();
    send_frame(8'hFE, 1'b1, 1'b1, 0);
    check_eq("post_rst_word", 32'(bus.word_out), 32'h0000_00FF);
    check_eq("post_rst_carry", 32'(bus.carry_out), 32'h0000_0000);

    // Randomized traffic: frames, restarts, gaps and backpressure.
    for (int f = 0; f < 150; f++) begin
      send_frame(W'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 int'($urandom_range(30)));
      for (int k = 0; k < int'($urandom_range(3)); k++)
        cycle(1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    for (int i = 0; i < 3000; i++)
      cycle(($urandom_range(99) < 70), ($urandom_range(99) < 6),
            1'($urandom_range(1)), ($urandom_range(99) < 60));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_twos_packer.md
# serial_twos_packer

Bit-serial to parallel packer on the downstream side of the serial one's-complement stage. It consumes the complemented LSB-first bit stream and adds 1 bit-serially, converting the one's-complement word into two's complement. It assembles the result into a WIDTH-bit word and presents that word on a one-entry valid/ready output buffer to the parallel consumer.

## Interface
- WIDTH, 8, bits per serial frame; legal range 2..32.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- bit_in  in  1  serial data bit, LSB first; sampled only when bit_valid=1.
- bit_valid  in  1  bit_in carries a frame bit this cycle.
- frame_start  in  1  qualified by bit_valid; marks bit_in as bit 0 of a new frame.
- word_out  out  WIDTH  assembled two's-complement word.
- word_valid  out  1  word_out holds an unconsumed word.
- word_ready  in  1  consumer accepts word_out when word_valid=1.
- carry_out  out  1  final carry of the +1; 1 only for an all-ones input frame. Travels with word_out.
- overrun  out  1  one-cycle pulse: a completed word was dropped because the buffer was full.

## Operation
- FSM states:
  - IDLE: waiting for a frame.
  - SHIFT: collecting bits 1..WIDTH-1.
- IDLE -> SHIFT: on bit_valid & frame_start. Bit 0 is absorbed in the same cycle. Bit counter becomes 1. Carry is seeded with 1, so sum = bit_in ^ 1 and carry = bit_in.
- bit_valid=1 with frame_start=0 in IDLE: bit ignored.
- SHIFT, per valid bit:
  - sum = bit_in ^ carry; carry <= bit_in & carry.
  - shreg <= {sum, shreg[WIDTH-1:1]}; counter increments.
  - bit_valid=0 stalls the frame; no gap limit.
- Frame completion: the valid bit with counter = WIDTH-1.
  - Word {sum, shreg[WIDTH-1:1]} and the final carry are offered to the output buffer.
  - FSM returns to IDLE.
- frame_start with bit_valid while in SHIFT: the partial frame is discarded silently. The current bit restarts a frame as bit 0 with carry re-seeded; state stays SHIFT and counter becomes 1.
- Output buffer, one entry (word_out, carry_out, word_valid):
  - Load when a frame completes and the buffer is empty, or is being emptied this cycle (word_valid & word_ready).
  - Completion while word_valid=1 and word_ready=0: new word dropped, buffer unchanged, overrun=1 for one cycle.
  - Completion and handshake in the same cycle: new word loads and word_valid stays 1; this is not an overrun.
  - Handshake without completion: word_valid <= 0. word_out and carry_out hold their last value.
- Arithmetic is modulo 2^WIDTH. The +1 carry out of the MSB appears only on carry_out, never folded into word_out.

## Timing
- Reset values (rst=0, immediate):
  - State IDLE, counter 0, carry 1, shreg 0.
  - word_out 0, carry_out 0, word_valid 0, overrun 0.
- Reset mid-frame or with a pending word: everything is lost and no word is emitted.
- First frame is accepted on the first rising edge with rst=1.
- Latency: the last bit is sampled at edge N; word_valid=1 and word_out is valid after edge N.
- Throughput: one frame per WIDTH valid bits. Back-to-back frames are allowed: frame_start may arrive in the cycle right after completion.
- word_valid never drops without a handshake. word_out and carry_out are stable while word_valid=1 and word_ready=0.
- overrun is registered and asserts after the completion edge.

## Test plan
- Basic conversion, WIDTH=8, word_ready=1: input frame 0xFA (one's complement of 0x05) sent LSB first with frame_start on bit 0 -> word_out=0xFB, carry_out=0, one word_valid pulse after the 8th bit edge.
- All-ones frame: input 0xFF -> word_out=0x00, carry_out=1. Then 0x00 -> word_out=0x01, carry_out=0.
- Backpressure, word_ready=0, frames 0xFA then 0xF0 back-to-back:
  - Response: 0xFB held with word_valid=1; second completion gives overrun=1 for exactly one cycle.
  - Then raise word_ready: 0xFB is consumed and word_valid drops to 0.
- Simultaneous completion and handshake: word_valid=1 holding 0xFB, word_ready=1 on the cycle frame 0x7F completes -> word_out=0x80 next cycle, word_valid stays 1, overrun=0.
- Abort and gaps:
  - Send 3 bits of a frame, then frame_start with a full 0x0E frame, with random bit_valid gaps -> single word 0x0F, no word from the partial frame.
  - Separately, bit_valid without frame_start in IDLE -> no output.
- Reset mid-frame: assert rst=0 after 5 bits -> all outputs 0 immediately. Release and send 0xFE -> word_out=0xFF, carry_out=0.
